// File: rtl/sram_i_stream_reader_pkg.sv
// Shared constants and types for the IFM SRAM read-side stream controller.
// Sizes match the CONV datapath input-feature-map SRAM.
package sram_i_stream_reader_pkg;

  localparam int WORD_AMOUNT  = 3136;
  localparam int BIT_PER_WORD = 145;
  localparam int FIFO_DEPTH   = 4;
  localparam int ADDR_W       = $clog2(WORD_AMOUNT);
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// Return buffer for SRAM read data; head word is read straight from the
// register array so out_data never depends on the SRAM port.
module sram_rd_fifo
  import sram_i_stream_reader_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = BIT_PER_WORD,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [PW-1:0] PMAX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;

  assign pop_ok = pop && !empty;
  assign full   = count == CMAX;
  assign empty  = count == '0;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= (wr_ptr == PMAX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= (rd_ptr == PMAX) ? '0 : rd_ptr + 1'b1;
      unique case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue throttling counts in-flight reads, so this must never fire.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/sram_i_stream_reader.sv
// IFM SRAM read controller: walks a wrapping address range and streams
// words out over valid/ready, hiding the SRAM's one-cycle read latency.
module sram_i_stream_reader
  import sram_i_stream_reader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W:0]         word_cnt,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic                    sram_we,
  input  logic [BIT_PER_WORD-1:0] sram_dout,
  output logic [BIT_PER_WORD-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_AMOUNT - 1);
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   iss_q;
  logic [ADDR_W:0]   pop_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  occ;
  logic              empty;
  logic              full;
  logic              rd_issue;
  logic              pop;
  logic              last_iss;
  logic              last_pop;

  // Reserve a slot for every read still in the SRAM pipeline.
  assign rd_issue = (state_q == READ) &&
    (({1'b0, occ} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_C);

  assign last_iss  = iss_q == cnt_q - 1'b1;
  assign last_pop  = pop_q == cnt_q - 1'b1;
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign out_last  = out_valid && last_pop;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign sram_we   = 1'b0;
  assign sram_addr = rd_issue ? ptr_q : addr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (word_cnt == '0) ? DONE : READ;
      READ:  if (rd_issue && last_iss) state_d = DRAIN;
      DRAIN: if (pop && last_pop) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      iss_q      <= '0;
      pop_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_issue;
      if (state_q == IDLE && start) begin
        ptr_q <= base_addr;
        cnt_q <= word_cnt;
        iss_q <= '0;
        pop_q <= '0;
      end
      if (rd_issue) begin
        addr_q <= ptr_q;
        ptr_q  <= (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
        iss_q  <= iss_q + 1'b1;
      end
      if (pop) pop_q <= pop_q + 1'b1;
    end
  end

  sram_rd_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   (sram_dout),
    .pop   (pop),
    .dout  (out_data),
    .count (occ),
    .full  (full),
    .empty (empty)
  );

endmodule
